// File: rtl/nefelimet_updown_cntr.sv
// 8-bit up/down counter with enable, synchronous load/clear, wrap or saturate mode
// and a power-of-two prescaler, presented on the standard user-project pin interface.
module nefelimet_updown_cntr #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESC_BITS = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [7:0]       ui_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uo_out,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe
);

  localparam int unsigned SEL_BITS = 3;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;

  logic                  cnt_en, up_dn, load, sat, clear;
  logic [SEL_BITS-1:0]   div_sel;
  logic [PRESC_BITS:0]   pow2;
  logic [PRESC_BITS-1:0] presc_mask;
  logic                  tick;
  logic [WIDTH-1:0]      step_val;

  assign cnt_en  = ui_in[0];
  assign up_dn   = ui_in[1];
  assign load    = ui_in[2];
  assign sat     = ui_in[3];
  assign div_sel = ui_in[6:4];
  assign clear   = ui_in[7];

  // Low n bits of the prescaler all ones marks the last cycle of each 2^n window.
  always_comb begin
    pow2       = (PRESC_BITS + 1)'(1) << div_sel;
    presc_mask = PRESC_BITS'(pow2 - (PRESC_BITS + 1)'(1));
    tick       = cnt_en && ((presc_q & presc_mask) == presc_mask);
  end

  // Single count step, honouring wrap or saturate at either end.
  always_comb begin
    step_val = count_q;
    if (up_dn) begin
      if (count_q == '1) step_val = sat ? '1 : '0;
      else               step_val = count_q + WIDTH'(1);
    end else begin
      if (count_q == '0) step_val = sat ? '0 : '1;
      else               step_val = count_q - WIDTH'(1);
    end
  end

  // Next state: clear > load > count > hold, all gated by ena.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    if (ena) begin
      if (clear) begin
        count_d = '0;
        presc_d = '0;
      end else if (load) begin
        count_d = uio_in;
        presc_d = '0;
      end else if (cnt_en) begin
        presc_d = presc_q + PRESC_BITS'(1);
        if (tick) count_d = step_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      presc_q <= '0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  assign uo_out  = count_q;
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_nefelimet_updown_cntr.sv
// Scoreboard bench for nefelimet_updown_cntr: a reference model pushes the expected
// count per driven cycle, which is popped and compared after the clock edge.
module tb_nefelimet_updown_cntr;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         m_count;
  int         m_presc;

  nefelimet_updown_cntr dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on the counter and the enabled-cycle prescaler.
  task automatic model(input logic r, input logic e, input logic [7:0] u, input logic [7:0] v);
    int p2;
    if (r) begin
      m_count = 0;
      m_presc = 0;
    end else if (e) begin
      if (u[7]) begin
        m_count = 0;
        m_presc = 0;
      end else if (u[2]) begin
        m_count = int'(v);
        m_presc = 0;
      end else if (u[0]) begin
        p2 = 1 << int'(u[6:4]);
        if ((m_presc % p2) == p2 - 1) begin
          if (u[1]) m_count = u[3] ? ((m_count + 1 > 255) ? 255 : m_count + 1) : (m_count + 1) % 256;
          else      m_count = u[3] ? ((m_count - 1 < 0) ? 0 : m_count - 1) : (m_count + 255) % 256;
        end
        m_presc = (m_presc + 1) % 128;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic [7:0] u, input logic [7:0] v);
    logic [7:0] exp;
    rst = r; ena = e; ui_in = u; uio_in = v;
    model(r, e, u, v);
    exp_q.push_back(8'(m_count));
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 8'h01, 8'h00);
    end else begin
      exp = exp_q.pop_front();
      check_eq("count", uo_out, exp);
    end
  endtask

  task automatic run(input int n, input logic [7:0] u, input logic [7:0] v);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, u, v);
  endtask

  initial begin
    logic [7:0] ru, rv;
    logic       re, rr;
    m_count = 0;
    m_presc = 0;
    rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    @(negedge clk);

    // Reset dominates every other input.
    cyc(1'b1, 1'b1, 8'hFF, 8'hAA);
    cyc(1'b1, 1'b1, 8'hFF, 8'hAA);
    check_eq("reset_value", uo_out, 8'h00);
    check_eq("uio_out_const", uio_out, 8'h00);
    check_eq("uio_oe_const", uio_oe, 8'h00);

    run(5, 8'h03, 8'h00);
    check_eq("up_5", uo_out, 8'h05);

    run(1, 8'h04, 8'h10);
    check_eq("load_10", uo_out, 8'h10);
    run(3, 8'h01, 8'h00);
    check_eq("down_3", uo_out, 8'h0D);

    run(1, 8'h04, 8'hFE);
    run(1, 8'h03, 8'h00); check_eq("wrap_up_ff", uo_out, 8'hFF);
    run(1, 8'h03, 8'h00); check_eq("wrap_up_00", uo_out, 8'h00);
    run(1, 8'h03, 8'h00); check_eq("wrap_up_01", uo_out, 8'h01);
    run(1, 8'h04, 8'h01);
    run(1, 8'h01, 8'h00); check_eq("wrap_dn_00", uo_out, 8'h00);
    run(1, 8'h01, 8'h00); check_eq("wrap_dn_ff", uo_out, 8'hFF);

    run(1, 8'h04, 8'hFE);
    run(4, 8'h0B, 8'h00); check_eq("sat_up", uo_out, 8'hFF);
    run(1, 8'h04, 8'h01);
    run(4, 8'h09, 8'h00); check_eq("sat_dn", uo_out, 8'h00);

    run(1, 8'h80, 8'h00);
    for (int i = 1; i <= 12; i++) begin
      run(1, 8'h23, 8'h00);
      if (i == 3)  check_eq("presc_c3", uo_out, 8'h00);
      if (i == 4)  check_eq("presc_c4", uo_out, 8'h01);
      if (i == 8)  check_eq("presc_c8", uo_out, 8'h02);
    end
    check_eq("presc_c12", uo_out, 8'h03);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 8'(8'hFF - i), 8'h3C);
    check_eq("ena_freeze", uo_out, 8'h03);

    run(1, 8'h87, 8'h55); check_eq("prio_clear", uo_out, 8'h00);
    run(1, 8'h07, 8'h55); check_eq("prio_load", uo_out, 8'h55);
    // Two enabled edges, pause, then two more: the fourth enabled edge steps once.
    run(2, 8'h23, 8'h00);
    run(3, 8'h22, 8'h00); check_eq("cnt_en_hold", uo_out, 8'h55);
    run(1, 8'h23, 8'h00); check_eq("presc_pre", uo_out, 8'h55);
    run(1, 8'h23, 8'h00); check_eq("presc_step", uo_out, 8'h56);

    // Mid-run reset.
    run(1, 8'h04, 8'h99);
    cyc(1'b1, 1'b1, 8'h07, 8'h77);
    check_eq("reset_midrun", uo_out, 8'h00);

    // Random mixed traffic against the model.
    for (int i = 0; i < 600; i++) begin
      ru = 8'($urandom);
      rv = 8'($urandom);
      if ($urandom_range(0, 9) < 7) ru[2] = 1'b0;
      if ($urandom_range(0, 9) < 8) ru[7] = 1'b0;
      if ($urandom_range(0, 1) == 0) ru[6:4] = 3'($urandom_range(0, 2));
      re = ($urandom_range(0, 9) != 0);
      rr = ($urandom_range(0, 49) == 0);
      cyc(rr, re, ru, rv);
    end
    check_eq("uio_out_end", uio_out, 8'h00);
    check_eq("uio_oe_end", uio_oe, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nefelimet_updown_cntr.md
Name: nefelimet_updown_cntr

Overview:
- 8-bit up/down counter with enable, synchronous load, clear, a wrap/saturate mode and a programmable power-of-two prescaler.
- Sits behind the standard user-project pin interface: dedicated inputs carry the controls, the bidirectional pins carry the load value, and the dedicated outputs show the count.
- Bidirectional pins are input-only in this block.

Parameters:
- WIDTH, 8, counter width; fixed at 8 to match the pin interface.
- PRESC_BITS, 7, prescaler width; supports divide ratios 2^0..2^7.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  design-selected enable; when low, all state holds.
- ui_in  input  8  control bits:
  - [0] cnt_en, count enable.
  - [1] up_dn: 1 = up, 0 = down.
  - [2] load.
  - [3] sat: 1 = saturate, 0 = wrap.
  - [6:4] div_sel n.
  - [7] clear.
- uio_in  input  8  load value.
- uo_out  output  8  current count value, driven directly from the count register.
- uio_out  output  8  constant 0x00.
- uio_oe  output  8  constant 0x00; all bidirectional pins are inputs.

Behaviour:
- Reset: rst = 1 at a rising edge sets count = 0x00 and prescaler = 0. rst overrides ena and every control. After reset, uo_out = 0x00.
- Hold: ena = 0 and rst = 0 means count and prescaler hold; all ui_in and uio_in bits are ignored.
- Priority, when ena = 1: clear > load > count > hold.
- clear (ui_in[7] = 1): next edge sets count = 0 and prescaler = 0.
- load (ui_in[2] = 1, clear = 0): next edge sets count = uio_in and prescaler = 0. Load ignores cnt_en and sat.
- Counting:
  - Prescaler increments on every edge with ena = 1, cnt_en = 1, no clear and no load. It wraps naturally.
  - tick = cnt_en AND (prescaler[n-1:0] all ones), where n = div_sel. n = 0 means tick every enabled cycle.
  - Result: one count step per 2^n enabled cycles. The first step occurs on the 2^n-th enabled edge after prescaler = 0.
- cnt_en = 0: count and prescaler both hold (the prescaler is not cleared).
- Step on tick, up (up_dn = 1):
  - count < 0xFF: count + 1.
  - count = 0xFF: wrap to 0x00 if sat = 0; stay at 0xFF if sat = 1.
- Step on tick, down (up_dn = 0):
  - count > 0x00: count - 1.
  - count = 0x00: wrap to 0xFF if sat = 0; stay at 0x00 if sat = 1.
- Mode changes: up_dn, sat and div_sel are sampled every cycle. Changing them mid-count takes effect on the next tick with no glitch. The prescaler is not reset on div_sel change.
- Latency: every control change is visible on uo_out one clock edge after it is sampled.
- Reset mid-operation: rst asserted during counting, load or clear yields count = 0 on that edge, regardless of other inputs.
- No combinational path from any input to uo_out.

Test Plan:
- Reset: rst = 1 for 2 cycles with ui_in = 0xFF, uio_in = 0xAA -> uo_out = 0x00. Then rst = 0, ena = 1, ui_in = 0x03 (up, div 1), 5 cycles -> uo_out = 0x05.
- Load and down count: ui_in = 0x04, uio_in = 0x10, 1 cycle -> 0x10. Then ui_in = 0x01 (down), 3 cycles -> 0x0D.
- Wrap:
  - Load 0xFE, count up 3 cycles with sat = 0 -> sequence 0xFF, 0x00, 0x01.
  - Load 0x01, count down 2 cycles -> 0x00, 0xFF.
- Saturate:
  - Load 0xFE, ui_in = 0x0B (up, sat), 4 cycles -> 0xFF, held.
  - Load 0x01, ui_in = 0x09 (down, sat), 4 cycles -> 0x00, held.
- Prescaler: clear, then ui_in = 0x23 (up, n = 2), 12 cycles -> count = 3, with steps on cycles 4, 8 and 12. ena = 0 for 5 cycles -> value frozen.
- Priority: ui_in = 0x87 (clear + load + count), uio_in = 0x55 -> 0x00. Then ui_in = 0x07 -> 0x55. cnt_en toggling mid-prescale -> prescaler holds, with no extra steps.
